// File: rtl/psg_phase_seq.sv
// -----------------------------------------------------------------------------
// psg_phase_seq
//
// Per-channel phase accumulator and channel sequencer for the PSG sine stage.
// On each accepted sample tick the block walks channels 0..NR_CHANNELS-1. For
// each channel it presents the upper OUTPUT_WIDTH bits of that channel's
// accumulator on a valid/ready stream. These bits are a two's-complement
// fraction of pi. After each word is accepted, the block advances that
// accumulator by the channel's programmable increment.
//
// Parameters
//   NR_CHANNELS   number of tone channels (1..255)
//   OUTPUT_WIDTH  radian word width presented downstream
//   PHASE_WIDTH   accumulator / increment width (>= OUTPUT_WIDTH)
//   CHW           channel index width, at least 1
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         new frames start only while high
//   sample_tick    one-cycle pulse at the sample rate
//   cfg_we         channel config write strobe
//   cfg_ch         channel being configured (out-of-range writes ignored)
//   cfg_inc        phase increment, 2^PHASE_WIDTH == 2*pi
//   cfg_clr        with cfg_we, also zeroes the accumulator and arms the
//                  zero flag for that channel
//   m_phase_d      radian word (accumulator MSBs)
//   m_phase_ch     channel of m_phase_d
//   m_phase_dv     data valid
//   m_phase_dr     data ready from downstream
//   m_phase_zero   first word after a clear
//   busy           a frame is in progress
//   overrun        one-cycle pulse when a sample_tick is dropped
// -----------------------------------------------------------------------------
module psg_phase_seq #(
  parameter int NR_CHANNELS  = 3,
  parameter int OUTPUT_WIDTH = 24,
  parameter int PHASE_WIDTH  = 32,
  parameter int CHW          = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sample_tick,
  input  logic                    cfg_we,
  input  logic [CHW-1:0]          cfg_ch,
  input  logic [PHASE_WIDTH-1:0]  cfg_inc,
  input  logic                    cfg_clr,
  output logic [OUTPUT_WIDTH-1:0] m_phase_d,
  output logic [CHW-1:0]          m_phase_ch,
  output logic                    m_phase_dv,
  input  logic                    m_phase_dr,
  output logic                    m_phase_zero,
  output logic                    busy,
  output logic                    overrun
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  generate
    if (PHASE_WIDTH < OUTPUT_WIDTH) begin : g_bad_width
      $fatal(1, "psg_phase_seq: PHASE_WIDTH must be >= OUTPUT_WIDTH");
    end
    if (NR_CHANNELS < 1 || NR_CHANNELS > 255) begin : g_bad_channels
      $fatal(1, "psg_phase_seq: NR_CHANNELS must be in 1..255");
    end
  endgenerate

  localparam logic [CHW-1:0] LAST_CH = CHW'(NR_CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CHW-1:0]          r_ch_cnt;

  logic [PHASE_WIDTH-1:0]  r_acc       [NR_CHANNELS];
  logic [PHASE_WIDTH-1:0]  r_inc       [NR_CHANNELS];
  logic                    r_zero_pend [NR_CHANNELS];

  logic [OUTPUT_WIDTH-1:0] r_phase_d;
  logic [CHW-1:0]          r_phase_ch;
  logic                    r_phase_zero;
  logic                    r_overrun;

  // ---------------------------------------------------------------------------
  // Control decodes
  // ---------------------------------------------------------------------------
  logic w_start;
  logic w_hs;
  logic w_last;

  assign w_start = (r_state == S_IDLE) && sample_tick && enable;
  assign w_hs    = (r_state == S_SEND) && m_phase_dr;
  assign w_last  = (r_ch_cnt == LAST_CH);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours; = here would create order-dependent
  // simulation that no longer matches the synthesised flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first guarantees every path drives
  // w_state_nxt, so no latch is inferred for unlisted cases.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: if (w_hs) w_state_nxt = w_last ? S_IDLE : S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Channel counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_cnt <= '0;
    end else if (w_start) begin
      r_ch_cnt <= '0;
    end else if (w_hs && !w_last) begin
      r_ch_cnt <= r_ch_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output word register: captured in LOAD and held through SEND, so the
  // fields stay stable while the consumer stalls, even if the accumulator
  // is cleared underneath.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase_d    <= '0;
      r_phase_ch   <= '0;
      r_phase_zero <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_phase_d    <= r_acc[r_ch_cnt][PHASE_WIDTH-1 -: OUTPUT_WIDTH];
      r_phase_ch   <= r_ch_cnt;
      r_phase_zero <= r_zero_pend[r_ch_cnt];
    end
  end

  // ---------------------------------------------------------------------------
  // Overrun: any tick that arrives while a frame is running is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= sample_tick && (r_state != S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel storage. A clearing config write overrides a handshake update
  // to the same channel in the same cycle. Out-of-range cfg_ch never matches
  // any index, so such writes fall away naturally.
  // ---------------------------------------------------------------------------
  // NOTE: these arrays have a defined reset state (zero phase, zero increment,
  // zero flag armed). They are therefore built from resettable flops, not
  // from an inferred RAM, which could not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_CHANNELS; i++) begin
        r_acc[i]       <= '0;
        r_inc[i]       <= '0;
        r_zero_pend[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NR_CHANNELS; i++) begin
        if (cfg_we && (cfg_ch == CHW'(i))) begin
          r_inc[i] <= cfg_inc;
        end

        if (cfg_we && cfg_clr && (cfg_ch == CHW'(i))) begin
          r_acc[i]       <= '0;
          r_zero_pend[i] <= 1'b1;
        end else if (w_hs && (r_ch_cnt == CHW'(i))) begin
          // Free modulo-2^PHASE_WIDTH wrap: phase is periodic.
          r_acc[i]       <= r_acc[i] + r_inc[i];
          r_zero_pend[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Valid is decoded straight from the state flop so that an
  // asynchronous reset drops it immediately.
  // ---------------------------------------------------------------------------
  assign m_phase_d    = r_phase_d;
  assign m_phase_ch   = r_phase_ch;
  assign m_phase_zero = r_phase_zero;
  assign m_phase_dv   = (r_state == S_SEND);
  assign busy         = (r_state != S_IDLE);
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_psg_phase_seq.sv
// -----------------------------------------------------------------------------
// tb_psg_phase_seq
//
// Directed testbench for psg_phase_seq (3 channels, 24-bit words, 32-bit
// phase). Stimulus pushes hand-computed expected words into a queue. A
// negedge monitor pops and compares the queue on every accepted output
// word. The monitor also checks stall stability and counts overrun pulses.
// -----------------------------------------------------------------------------
module tb_psg_phase_seq;

  localparam int N   = 3;
  localparam int OW  = 24;
  localparam int PW  = 32;
  localparam int CHW = 2;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          sample_tick;
  logic          cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [PW-1:0] cfg_inc;
  logic          cfg_clr;
  logic [OW-1:0] m_phase_d;
  logic [CHW-1:0] m_phase_ch;
  logic          m_phase_dv;
  logic          m_phase_dr;
  logic          m_phase_zero;
  logic          busy;
  logic          overrun;

  psg_phase_seq #(
    .NR_CHANNELS (N),
    .OUTPUT_WIDTH(OW),
    .PHASE_WIDTH (PW),
    .CHW         (CHW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sample_tick (sample_tick),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_inc     (cfg_inc),
    .cfg_clr     (cfg_clr),
    .m_phase_d   (m_phase_d),
    .m_phase_ch  (m_phase_ch),
    .m_phase_dv  (m_phase_dv),
    .m_phase_dr  (m_phase_dr),
    .m_phase_zero(m_phase_zero),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic        z;
    logic [23:0] d;
  } exp_t;

  exp_t q[$];
  int   total   = 0;
  int   bad     = 0;
  int   ovr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [23:0] d, input logic z);
    exp_t e;
    e.ch = ch;
    e.z  = z;
    e.d  = d;
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [23:0] d0, input logic z0,
                            input logic [23:0] d1, input logic z1,
                            input logic [23:0] d2, input logic z2);
    push(2'd0, d0, z0);
    push(2'd1, d1, z1);
    push(2'd2, d2, z2);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: scoreboard pop/compare, stall stability, overrun counting
  // ---------------------------------------------------------------------------
  logic        prev_stall = 1'b0;
  logic [25:0] prev_word  = '0;

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [26:0] ev;
    if (rst_n && m_phase_dv && m_phase_dr) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected output: got ch=%0d d=%h z=%0d want none",
                 m_phase_ch, m_phase_d, m_phase_zero);
      end else begin
        e  = q.pop_front();
        ev = e;
        check($sformatf("out ch%0d", e.ch),
              32'({m_phase_ch, m_phase_zero, m_phase_d}), 32'(ev));
      end
    end
    if (prev_stall) begin
      check("stall dv", 32'(m_phase_dv), 32'd1);
      check("stall word", 32'({m_phase_ch, m_phase_d}), 32'(prev_word));
    end
    prev_stall = rst_n && m_phase_dv && !m_phase_dr;
    prev_word  = {m_phase_ch, m_phase_d};
    if (overrun) ovr_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
  endtask

  task automatic cfg(input logic [CHW-1:0] ch, input logic [PW-1:0] inc, input logic clr);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_clr = clr;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_clr = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'({busy, q.size() != 0}), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : stim
    logic [23:0] w0 [5];
    logic [23:0] w1 [5];
    int          ovr_before;

    enable = 0; sample_tick = 0; cfg_we = 0; cfg_ch = '0; cfg_inc = '0;
    cfg_clr = 0; m_phase_dr = 1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset dv",   32'(m_phase_dv), 32'd0);
    check("reset word", 32'({m_phase_ch, m_phase_zero, m_phase_d}), 32'd0);
    check("reset busy", 32'({busy, overrun}), 32'd0);
    rst_n = 1'b1;

    // Tick with enable low is ignored (any output would hit the monitor).
    tick();
    repeat (8) @(posedge clk);
    #1;
    check("disabled tick busy", 32'(busy), 32'd0);
    check("disabled tick overrun", 32'(ovr_cnt), 32'd0);

    // Basic accumulation, 3 frames.
    enable = 1'b1;
    cfg(2'd0, 32'h0100_0000, 1'b0);
    cfg(2'd1, 32'h0080_0000, 1'b0);
    cfg(2'd2, 32'h0000_0000, 1'b0);

    push_frame(24'h000000, 1, 24'h000000, 1, 24'h000000, 1);
    tick();
    check("LOAD dv", 32'(m_phase_dv), 32'd0);
    check("LOAD busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("T+2 dv", 32'(m_phase_dv), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("last SEND busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("frame end busy", 32'(busy), 32'd0);
    wait_done("frame1");
    repeat (12) @(posedge clk);

    push_frame(24'h010000, 0, 24'h008000, 0, 24'h000000, 0);
    tick();
    wait_done("frame2");
    repeat (12) @(posedge clk);

    push_frame(24'h020000, 0, 24'h010000, 0, 24'h000000, 0);
    tick();
    wait_done("frame3");
    check("no overrun basic", 32'(ovr_cnt), 32'd0);

    // Quarter-turn increment on ch0 with wrap; ticks at minimum spacing.
    cfg(2'd0, 32'h4000_0000, 1'b1);
    w0 = '{24'h000000, 24'h400000, 24'h800000, 24'hC00000, 24'h000000};
    w1 = '{24'h018000, 24'h020000, 24'h028000, 24'h030000, 24'h038000};
    for (int i = 0; i < 5; i++) begin
      push_frame(w0[i], (i == 0), w1[i], 0, 24'h000000, 0);
      tick();
      repeat (5) @(posedge clk);
    end
    wait_done("wrap frames");
    check("no overrun min spacing", 32'(ovr_cnt), 32'd0);

    // Consumer stall during ch1 SEND.
    push_frame(24'h400000, 0, 24'h040000, 0, 24'h000000, 0);
    tick();
    @(posedge clk);
    @(posedge clk); #1 m_phase_dr = 1'b0;
    @(posedge clk); #1;
    check("stall on ch1", 32'({m_phase_dv, m_phase_ch}), 32'({1'b1, 2'd1}));
    repeat (7) @(posedge clk);
    #1 m_phase_dr = 1'b1;
    wait_done("stall frame");
    push_frame(24'h800000, 0, 24'h048000, 0, 24'h000000, 0);
    tick();
    wait_done("after stall");

    // Tick 3 cycles after the first: dropped with an overrun pulse.
    ovr_before = ovr_cnt;
    push_frame(24'hC00000, 0, 24'h050000, 0, 24'h000000, 0);
    tick();
    @(posedge clk);
    tick();
    wait_done("overrun frame");
    check("overrun pulses", 32'(ovr_cnt - ovr_before), 32'd1);
    push_frame(24'h000000, 0, 24'h058000, 0, 24'h000000, 0);
    tick();
    wait_done("after overrun");

    // Clear ch0 and write an ignored out-of-range channel. Drop enable
    // mid-frame. Update ch2's increment before ch2 is sent.
    cfg(2'd0, 32'h4000_0000, 1'b1);
    cfg(2'd3, 32'h1234_5678, 1'b1);
    push_frame(24'h000000, 1, 24'h060000, 0, 24'h000000, 0);
    tick();
    enable = 1'b0;
    wait_done("clear frame");
    enable = 1'b1;
    push_frame(24'h400000, 0, 24'h068000, 0, 24'h000000, 0);
    tick();
    cfg(2'd2, 32'h0010_0000, 1'b0);
    wait_done("post-clear frame");
    push_frame(24'h800000, 0, 24'h070000, 0, 24'h001000, 0);
    tick();
    wait_done("late inc frame");

    // Reset during ch1 SEND.
    push_frame(24'hC00000, 0, 24'h078000, 0, 24'h002000, 0);
    tick();
    @(posedge clk);
    @(posedge clk); #1 m_phase_dr = 1'b0;
    @(posedge clk); #1;
    check("pre-reset dv", 32'({m_phase_dv, m_phase_ch}), 32'({1'b1, 2'd1}));
    rst_n = 1'b0;
    #1;
    check("mid-reset dv", 32'(m_phase_dv), 32'd0);
    check("mid-reset busy", 32'(busy), 32'd0);
    q.delete();
    m_phase_dr = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame(24'h000000, 1, 24'h000000, 1, 24'h000000, 1);
    tick();
    wait_done("post-reset frame");
    push_frame(24'h000000, 0, 24'h000000, 0, 24'h000000, 0);
    tick();
    wait_done("post-reset frame2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
